seg7_countdown_monitor: RTL and testbench
=========================================

Name: seg7_countdown_monitor

Overview:
- Receive side of the two-digit 7-segment display bus driven by the countdown-timer datapath.
- Takes the two active-low segment patterns (units, tens), waits until each pattern has been stable, and decodes it back to BCD.
- Checks that successive values form a legal countdown, and measures the clock period between ticks.
- Used as an on-chip self-check and as the bench-side observer for the timer block.

Parameters:
- STABLE_CYC, 4, consecutive identical samples of both patterns required before a value is accepted (range 1..255).
- WRAP_VAL, 29, BCD value (tens*10+units) loaded after 00; the only legal successor of 00.
- PER_W, 27, width of the tick-period counter and of the period output.

Ports:
- CLK  in  1  system clock (50 MHz).
- CLR  in  1  reset; one clock; reset is asynchronous and active-low.
- seg_units  in  7  units-digit pattern. Bit 6 = segment a … bit 0 = segment g. Active-low (0 = lit).
- seg_tens  in  7  tens-digit pattern, same encoding.
- dig0  out  4  accepted units value, BCD.
- dig1  out  4  accepted tens value, BCD.
- valid  out  1  dig0/dig1 hold an accepted legal BCD value.
- tick  out  1  one-cycle pulse when a new accepted value differs from the previous one.
- seq_err  out  1  one-cycle pulse: the accepted change is not a legal countdown step.
- bad_pat  out  1  one-cycle pulse: an accepted pattern is not a decimal digit 0-9.
- err_cnt  out  8  count of seq_err plus bad_pat events, saturating at 255.
- period  out  PER_W  clocks between the last two ticks.

Behaviour:
- Reset (CLR low, async): all outputs 0; stability counter 0; FSM in SYNC; held patterns cleared to 7'h7F (blank).
- Sampling:
  - Register both inputs each clock.
  - If either differs from the previous sample, the stability counter goes to 0.
  - Otherwise it increments, saturating at STABLE_CYC.
  - A pattern pair is accepted on the cycle the counter reaches STABLE_CYC−1 → STABLE_CYC. One acceptance per stable period.
- Decode table (active-low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Patterns for A–F, and any other pattern, are non-decimal.
- FSM states: SYNC and TRACK.
  - SYNC: a legal accept loads dig0/dig1, sets valid=1, goes to TRACK. No sequence check, no tick.
  - TRACK, accept equal to the current value: no action.
  - TRACK, accept different from the current value:
    - tick=1; period ← cycles since the previous tick; period counter restarts at 1.
    - Legal step: value−1, or 00→WRAP_VAL. Examples: 20→19, 10→09.
    - Illegal step: seq_err=1 and the value is still loaded (resynchronise on the new value).
  - Any state, non-decimal accept: bad_pat=1, valid=0, dig0/dig1 hold, state → SYNC, period counter cleared.
- Same-cycle events:
  - bad_pat and seq_err never pulse together; bad_pat takes priority.
  - err_cnt increments by exactly 1 per event.
- Period counter: free-runs in TRACK and saturates at all-ones (no wrap). The first tick after SYNC reports cycles since entering TRACK.
- Latency: input change → dig/tick update = STABLE_CYC+1 clocks.
- CLR asserted mid-operation: immediate return to the reset state. No pulse may be emitted on the release edge.

Optional Feature:
- Macro SEG7_MON_LIGHT_CHECK_EN.
- Defined:
  - Adds ports green (in 1), red (in 1) and light_err (out 1, pulse).
  - Inputs are sampled with the same stability filter.
  - light_err pulses if green==red on any accept in TRACK.
  - light_err also pulses if the lights toggle on a step other than 00→WRAP_VAL, or fail to toggle on 00→WRAP_VAL.
  - light_err events also count into err_cnt.
- Undefined: those ports and that logic are absent; behaviour is otherwise identical.

Decomposition:
- Package seg7_pkg:
  - Segment pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - 4-bit BCD digit typedef.
  - FSM state enum {SYNC, TRACK}.
- Sub-module seg7_to_bcd:
  - Combinational pattern → {digit[3:0], is_dec}.
  - Instantiated once per digit.

Test Plan:
- Reset, then hold tens=SEG_2, units=SEG_9 for 10 clocks → valid=1 at clock STABLE_CYC+1; dig1=2, dig0=9; no tick, no seq_err.
- From 29, step 28, 27 every 100 clocks → tick pulses; second period=100; err_cnt=0.
- From 00, present 29 → tick, no seq_err. From 15, present 13 → seq_err pulse, dig=13, err_cnt=1.
- Toggle units pattern every 2 clocks (glitch < STABLE_CYC) → no accept, outputs unchanged.
- Present units=A (0001000) → bad_pat, valid=0, state SYNC. Then present 05 → valid=1, no tick.
- With SEG7_MON_LIGHT_CHECK_EN: 00→29 with green held at 1 → light_err pulse, err_cnt+1. Assert CLR mid-count → all outputs 0 asynchronously.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment countdown monitor: active-low segment
// patterns (bit 6 = segment a ... bit 0 = segment g), the BCD digit type,
// the monitor FSM state and a BCD-pair-to-binary helper.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } mon_state_t;

    // tens*10 + units as a 7-bit binary value (only meaningful for decimal digits)
    function automatic logic [6:0] bcd_pair_value(input bcd_t tens, input bcd_t units);
        logic [6:0] t7;
        t7 = {3'b000, tens};
        return (t7 << 3) + (t7 << 1) + {3'b000, units};
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low 7-segment pattern back to a BCD
// digit. Anything that is not exactly one of the ten decimal patterns
// (including the A-F hex glyphs and blank) reports is_dec = 0 and digit 0.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output bcd_t       digit,
    output logic       is_dec
);

    // Exact-match lookup of the ten legal digit patterns
    always_comb begin
        // NOTE: both outputs get a default before the case, so no input value can leave them unassigned and infer a latch.
        digit  = 4'd0;
        is_dec = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: is_dec = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_countdown_monitor.sv
// Receive side of the two-digit 7-segment countdown bus. Filters the raw
// patterns for stability, decodes them to BCD, checks that successive
// accepted values form a legal countdown (value-1, or 00 -> WRAP_VAL) and
// measures the clock count between ticks.
// Optional traffic-light consistency check: define SEG7_MON_LIGHT_CHECK_EN.
module seg7_countdown_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int WRAP_VAL   = 29,
    parameter int PER_W      = 27
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [6:0]       seg_units,
    input  logic [6:0]       seg_tens,
`ifdef SEG7_MON_LIGHT_CHECK_EN
    input  logic             green,
    input  logic             red,
    output logic             light_err,
`endif
    output bcd_t             dig0,
    output bcd_t             dig1,
    output logic             valid,
    output logic             tick,
    output logic             seq_err,
    output logic             bad_pat,
    output logic [7:0]       err_cnt,
    output logic [PER_W-1:0] period
);

    localparam logic [7:0]       STAB_MAX = 8'(STABLE_CYC);
    localparam logic [7:0]       STAB_ACC = 8'(STABLE_CYC - 1);
    localparam logic [6:0]       WRAP_BIN = 7'(WRAP_VAL);
    localparam logic [PER_W-1:0] PER_ONE  = {{(PER_W-1){1'b0}}, 1'b1};
    localparam logic [PER_W-1:0] PER_MAX  = '1;

    logic [6:0]       smp_units;
    logic [6:0]       smp_tens;
    logic [7:0]       stab_cnt;
    logic             changed;
    logic             accept;

`ifdef SEG7_MON_LIGHT_CHECK_EN
    logic             smp_green;
    logic             smp_red;
    logic             held_green;
    logic             held_red;
`endif

    bcd_t             new_units;
    bcd_t             new_tens;
    logic             units_dec;
    logic             tens_dec;
    logic             legal;
    logic [6:0]       new_val;
    logic [6:0]       cur_val;
    logic             differs;
    logic             is_wrap;
    logic             step_ok;
    logic             ev_bad;
    logic             ev_seq;
    logic             ev_light;
    logic [1:0]       ev_sum;
    logic [8:0]       err_sum;
    logic [7:0]       err_next;

    mon_state_t       state;
    logic [PER_W-1:0] per_cnt;

    // Any difference between the current inputs and the last sample restarts the filter
    always_comb begin
        changed = (seg_units != smp_units) || (seg_tens != smp_tens);
`ifdef SEG7_MON_LIGHT_CHECK_EN
        changed = changed || (green != smp_green) || (red != smp_red);
`endif
        accept  = !changed && (stab_cnt == STAB_ACC);
    end

    // Input sample registers and saturating stability counter
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            // NOTE: samples reset to blank so whatever is on the bus at release counts as a change and must re-qualify.
            smp_units <= SEG_BLANK;
            smp_tens  <= SEG_BLANK;
            stab_cnt  <= 8'd0;
`ifdef SEG7_MON_LIGHT_CHECK_EN
            smp_green <= 1'b0;
            smp_red   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            smp_units <= seg_units;
            smp_tens  <= seg_tens;
`ifdef SEG7_MON_LIGHT_CHECK_EN
            smp_green <= green;
            smp_red   <= red;
`endif
            if (changed) begin
                stab_cnt <= 8'd0;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 8'd1;
            end
        end
    end

    seg7_to_bcd u_dec_units (
        .seg    (smp_units),
        .digit  (new_units),
        .is_dec (units_dec)
    );

    seg7_to_bcd u_dec_tens (
        .seg    (smp_tens),
        .digit  (new_tens),
        .is_dec (tens_dec)
    );

    // Classify the accepted pair: bad pattern, countdown step legality, light checks, error count
    always_comb begin
        new_val  = bcd_pair_value(new_tens, new_units);
        cur_val  = bcd_pair_value(dig1, dig0);
        legal    = units_dec && tens_dec;
        differs  = (new_tens != dig1) || (new_units != dig0);
        is_wrap  = (cur_val == 7'd0) && (new_val == WRAP_BIN);
        step_ok  = is_wrap || ((cur_val != 7'd0) && (new_val == cur_val - 7'd1));
        ev_bad   = accept && !legal;
        ev_seq   = accept && legal && (state == TRACK) && differs && !step_ok;
        ev_light = 1'b0;
`ifdef SEG7_MON_LIGHT_CHECK_EN
        if (accept && (state == TRACK)) begin
            if (smp_green == smp_red) begin
                ev_light = 1'b1;
            end else if (legal && differs &&
                         (({smp_green, smp_red} != {held_green, held_red}) != is_wrap)) begin
                ev_light = 1'b1;
            end
        end
`endif
        ev_sum   = {1'b0, ev_bad} + {1'b0, ev_seq} + {1'b0, ev_light};
        err_sum  = {1'b0, err_cnt} + {7'b0, ev_sum};
        err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // SYNC/TRACK FSM with registered digit, pulse, error and period outputs
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state      <= SYNC;
            dig0       <= 4'd0;
            dig1       <= 4'd0;
            valid      <= 1'b0;
            tick       <= 1'b0;
            seq_err    <= 1'b0;
            bad_pat    <= 1'b0;
            err_cnt    <= 8'd0;
            period     <= '0;
            per_cnt    <= '0;
`ifdef SEG7_MON_LIGHT_CHECK_EN
            light_err  <= 1'b0;
            held_green <= 1'b0;
            held_red   <= 1'b0;
`endif
        end else begin
            tick    <= 1'b0;
            seq_err <= 1'b0;
            bad_pat <= 1'b0;
            err_cnt <= err_next;
`ifdef SEG7_MON_LIGHT_CHECK_EN
            light_err <= ev_light;
`endif
            if ((state == TRACK) && (per_cnt != PER_MAX)) begin
                per_cnt <= per_cnt + PER_ONE;
            end

            if (accept) begin
                if (!legal) begin
                    // Non-decimal glyph: drop validity, keep the last digits, resync
                    bad_pat <= 1'b1;
                    valid   <= 1'b0;
                    state   <= SYNC;
                    per_cnt <= '0;
                end else begin
`ifdef SEG7_MON_LIGHT_CHECK_EN
                    held_green <= smp_green;
                    held_red   <= smp_red;
`endif
                    if (state == SYNC) begin
                        dig0    <= new_units;
                        dig1    <= new_tens;
                        valid   <= 1'b1;
                        state   <= TRACK;
                        per_cnt <= PER_ONE;
                    end else if (differs) begin
                        // Illegal steps still load the new value so tracking resyncs on it
                        dig0    <= new_units;
                        dig1    <= new_tens;
                        tick    <= 1'b1;
                        seq_err <= !step_ok;
                        period  <= per_cnt;
                        per_cnt <= PER_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_countdown_monitor.sv
// Scoreboard bench for seg7_countdown_monitor: stimulus pushes the expected
// response of each presented value into a queue; a monitor on the falling
// edge pops and compares whenever the DUT shows an event (tick, seq_err,
// bad_pat, light_err or a change of valid), including the exact cycle.
module tb_seg7_countdown_monitor;

    localparam int S     = 4;
    localparam int PER_W = 27;

    typedef struct {
        int         cyc;
        logic [3:0] d1;
        logic [3:0] d0;
        bit         valid;
        bit         tick;
        bit         seq;
        bit         bad;
        bit         lerr;
        logic [7:0] err;
        bit         chk_per;
        int         per;
    } exp_t;

    logic             CLK = 1'b0;
    logic             CLR = 1'b0;
    logic [6:0]       seg_units;
    logic [6:0]       seg_tens;
    logic [3:0]       dig0;
    logic [3:0]       dig1;
    logic             valid;
    logic             tick;
    logic             seq_err;
    logic             bad_pat;
    logic [7:0]       err_cnt;
    logic [PER_W-1:0] period;
`ifdef SEG7_MON_LIGHT_CHECK_EN
    logic             green;
    logic             red;
    logic             light_err;
    logic             lg;
    logic             lr;
`endif

    logic [6:0] pat [10];
    exp_t       q [$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         exp_err = 0;
    int         last_ref = 0;
    int         hd1 = 0;
    int         hd0 = 0;
    bit         prev_valid = 1'b0;
    bit         ev;
    exp_t       me;

    seg7_countdown_monitor #(
        .STABLE_CYC (S),
        .WRAP_VAL   (29),
        .PER_W      (PER_W)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .seg_units (seg_units),
        .seg_tens  (seg_tens),
`ifdef SEG7_MON_LIGHT_CHECK_EN
        .green     (green),
        .red       (red),
        .light_err (light_err),
`endif
        .dig0      (dig0),
        .dig1      (dig1),
        .valid     (valid),
        .tick      (tick),
        .seq_err   (seq_err),
        .bad_pat   (bad_pat),
        .err_cnt   (err_cnt),
        .period    (period)
    );

    always #10 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Queue the response expected S+1 clocks after the inputs just driven
    task automatic push_ev(input int t, input int u, input bit v, input bit tk, input bit sq,
                           input bit bd, input bit le, input bit new_ref);
        exp_t e;
        exp_err   = exp_err + int'(sq) + int'(bd) + int'(le);
        e.cyc     = cyc + S + 1;
        e.d1      = 4'(t);
        e.d0      = 4'(u);
        e.valid   = v;
        e.tick    = tk;
        e.seq     = sq;
        e.bad     = bd;
        e.lerr    = le;
        e.err     = 8'(exp_err);
        e.chk_per = tk;
        e.per     = e.cyc - last_ref;
        if (new_ref) last_ref = e.cyc;
        q.push_back(e);
    endtask

    task automatic present(input int t, input int u, input bit tog, input bit e_rise,
                           input bit e_tick, input bit e_seq, input bit e_lerr, input int hold);
        @(posedge CLK); #1;
`ifdef SEG7_MON_LIGHT_CHECK_EN
        if (tog) begin
            lg = ~lg;
            lr = ~lr;
        end
        green = lg;
        red   = lr;
`endif
        seg_tens  = pat[t];
        seg_units = pat[u];
        if (e_rise || e_tick || e_seq || e_lerr) begin
            push_ev(t, u, 1'b1, e_tick, e_seq, 1'b0, e_lerr, e_rise || e_tick);
            hd1 = t;
            hd0 = u;
        end
        repeat (hold) @(posedge CLK);
    endtask

    task automatic present_bad(input logic [6:0] pt, input logic [6:0] pu, input int hold);
        @(posedge CLK); #1;
        seg_tens  = pt;
        seg_units = pu;
        push_ev(hd1, hd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (hold) @(posedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dig0"}, 32'(dig0), 0);
        check({tag, "_dig1"}, 32'(dig1), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_tick"}, 32'(tick), 0);
        check({tag, "_seq_err"}, 32'(seq_err), 0);
        check({tag, "_bad_pat"}, 32'(bad_pat), 0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 0);
        check({tag, "_period"}, 32'(period), 0);
`ifdef SEG7_MON_LIGHT_CHECK_EN
        check({tag, "_light_err"}, 32'(light_err), 0);
`endif
    endtask

    // Monitor: every visible DUT event must match the head of the scoreboard
    always @(negedge CLK) begin
        if (!CLR) begin
            prev_valid = 1'b0;
        end else begin
            ev = tick || seq_err || bad_pat || (valid != prev_valid);
`ifdef SEG7_MON_LIGHT_CHECK_EN
            ev = ev || light_err;
`endif
            if (ev) begin
                check("event_expected", (q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (q.size() != 0) begin
                    me = q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(me.cyc));
                    check("dig1", 32'(dig1), 32'(me.d1));
                    check("dig0", 32'(dig0), 32'(me.d0));
                    check("valid", 32'(valid), 32'(me.valid));
                    check("tick", 32'(tick), 32'(me.tick));
                    check("seq_err", 32'(seq_err), 32'(me.seq));
                    check("bad_pat", 32'(bad_pat), 32'(me.bad));
                    check("err_cnt", 32'(err_cnt), 32'(me.err));
                    if (me.chk_per) check("period", 32'(period), 32'(me.per));
`ifdef SEG7_MON_LIGHT_CHECK_EN
                    check("light_err", 32'(light_err), 32'(me.lerr));
`endif
                end
            end
            prev_valid = valid;
        end
    end

    initial begin
        pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
`ifdef SEG7_MON_LIGHT_CHECK_EN
        lg    = 1'b1;
        lr    = 1'b0;
        green = lg;
        red   = lr;
`endif
        // Reset with 29 already on the bus
        seg_tens  = pat[2];
        seg_units = pat[9];
        CLR       = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");

        // Release: 29 accepted S+1 clocks later, valid rises, no tick
        @(posedge CLK); #1;
        CLR = 1'b1;
        push_ev(2, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        hd1 = 2;
        hd0 = 9;
        repeat (9) @(posedge CLK);

        // 29 -> 28 -> 27 spaced 100 clocks
        present(2, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 99);
        present(2, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 99);
        check("second_period", 32'(period), 32'd100);
        check("err_cnt_clean", 32'(err_cnt), 32'd0);

        // Count down to 00, wrap to 29 (lights toggle on the wrap), down to 15
        for (int v = 26; v >= 0; v--) present(v / 10, v % 10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7);
        present(2, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7);
        for (int v = 28; v >= 15; v--) present(v / 10, v % 10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7);

        // 15 -> 13 skips a value
        present(1, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 20);
        check("seq_err_count", 32'(err_cnt), 32'd1);

        // Units glitching every 2 clocks never qualifies
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            seg_units = (i % 2 == 0) ? pat[2] : pat[3];
            @(posedge CLK);
        end
        repeat (10) @(posedge CLK);
        #1;
        check("glitch_dig1", 32'(dig1), 32'd1);
        check("glitch_dig0", 32'(dig0), 32'd3);
        check("glitch_valid", 32'(valid), 32'd1);

        // Hex 'A' on units: bad pattern, then resync on 05 without a tick
        present_bad(pat[1], 7'b0001000, 20);
        present(0, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20);

`ifdef SEG7_MON_LIGHT_CHECK_EN
        // 05 down to 00 with lights steady, then 00 -> 29 without a toggle
        for (int v = 4; v >= 0; v--) present(0, v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7);
        present(2, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 20);
`endif

        // CLR mid-operation clears everything without waiting for a clock edge
        @(posedge CLK); #3;
        CLR = 1'b0;
        #1;
        check_all_zero("async_clr");
        exp_err = 0;
        repeat (3) @(posedge CLK);
        #1;
        CLR = 1'b1;
        push_ev(hd1, hd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge CLK);
        #1;

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
